// File: rtl/stop_check_multi_rx.sv
// UART RX stop-bit checker: validates 1..NUM_STOP_MAX stop bits per frame and
// reports per-frame stop error / break plus a saturating framing-error count.
module stop_check_multi_rx #(
  parameter int NUM_STOP_MAX = 2,
  parameter int CFG_W        = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 CLK_STOP_CHECK,
  input  logic                 RST_STOP_CHECK,
  input  logic                 frame_start,
  input  logic [CFG_W-1:0]     stop_bits_cfg,
  input  logic                 stp_chk_en,
  input  logic                 sampled_bit,
  input  logic                 data_zero,
  input  logic                 err_cnt_clr,
  output logic                 stp_err,
  output logic                 break_det,
  output logic                 frame_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {IDLE, CHECK} state_t;

  localparam logic [CFG_W-1:0]     MAX_CFG = CFG_W'(NUM_STOP_MAX);
  localparam logic [CFG_W-1:0]     ONE_CFG = CFG_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [CFG_W-1:0]     n_stop_q, n_stop_d;
  logic [CFG_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 err_acc_q, err_acc_d;
  logic                 zero_acc_q, zero_acc_d;
  logic                 stp_err_q, stp_err_d;
  logic                 break_det_q, break_det_d;
  logic                 frame_done_q, frame_done_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic err_now, zero_now, cnt_inc;

  always_comb begin
    state_d      = state_q;
    n_stop_d     = n_stop_q;
    bit_idx_d    = bit_idx_q;
    err_acc_d    = err_acc_q;
    zero_acc_d   = zero_acc_q;
    stp_err_d    = stp_err_q;
    break_det_d  = break_det_q;
    frame_done_d = 1'b0;
    cnt_inc      = 1'b0;
    err_now      = err_acc_q | ~sampled_bit;
    zero_now     = zero_acc_q & ~sampled_bit & data_zero;

    // frame_start always wins: it aborts any frame in flight and masks a coincident strobe
    if (frame_start) begin
      state_d     = CHECK;
      bit_idx_d   = '0;
      err_acc_d   = 1'b0;
      zero_acc_d  = 1'b1;
      stp_err_d   = 1'b0;
      break_det_d = 1'b0;
      if (stop_bits_cfg == '0)
        n_stop_d = ONE_CFG;
      else if (stop_bits_cfg > MAX_CFG)
        n_stop_d = MAX_CFG;
      else
        n_stop_d = stop_bits_cfg;
    end else if (state_q == CHECK && stp_chk_en) begin
      err_acc_d  = err_now;
      zero_acc_d = zero_now;
      if (bit_idx_q == n_stop_q - ONE_CFG) begin
        state_d      = IDLE;
        stp_err_d    = err_now;
        break_det_d  = zero_now;
        frame_done_d = 1'b1;
        cnt_inc      = err_now;
      end else begin
        bit_idx_d = bit_idx_q + ONE_CFG;
      end
    end

    if (err_cnt_clr)
      err_cnt_d = '0;
    else if (cnt_inc && err_cnt_q != CNT_MAX)
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    else
      err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
    if (!RST_STOP_CHECK) begin
      state_q      <= IDLE;
      n_stop_q     <= ONE_CFG;
      bit_idx_q    <= '0;
      err_acc_q    <= 1'b0;
      zero_acc_q   <= 1'b0;
      stp_err_q    <= 1'b0;
      break_det_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      n_stop_q     <= n_stop_d;
      bit_idx_q    <= bit_idx_d;
      err_acc_q    <= err_acc_d;
      zero_acc_q   <= zero_acc_d;
      stp_err_q    <= stp_err_d;
      break_det_q  <= break_det_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign stp_err    = stp_err_q;
  assign break_det  = break_det_q;
  assign frame_done = frame_done_q;
  assign err_cnt    = err_cnt_q;

endmodule
